dsp_sample_sequencer: RTL and testbench
=======================================

Name: dsp_sample_sequencer

Overview:
- Parametrised sample-flow sequencer for the DSP engine: accepts a multi-channel input frame, then sequences four steps:
  - input-gain request;
  - pipeline tick;
  - wait on any number of pipelines;
  - output mix.
- Returns the mixed frame with a ready flag.
- Adds behaviour the current engine FSM lacks:
  - per-pipeline wait mask;
  - overrun detection with drop counting;
  - watchdog timeout with abort.
- Sits between the sample I/O and the mixer/pipeline instances inside the engine top.

Parameters:
- data_width, 16, sample width in bits.
- n_channels, 2, samples per frame.
- n_pipelines, 2, number of pipelines ticked and awaited.
- timeout_cycles, 1024, maximum cycles in any wait state before abort; must be ≥ 2.
- ctr_width, 32, width of the frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_samples  in  n_channels*data_width  input frame, channel 0 in the LSBs.
- sample_valid  in  1  input frame strobe.
- gain_samples  out  n_channels*data_width  latched input frame to the mixer.
- apply_gain  out  1  one-cycle input-gain request.
- gain_done  in  1  gain-applied acknowledge.
- pipeline_tick  out  1  one-cycle pipeline start.
- pipeline_ready  in  n_pipelines  per-pipeline done.
- pipeline_mask  in  n_pipelines  1 = wait on this pipeline.
- mix  out  1  one-cycle mix request.
- mix_done  in  1  mixed frame valid.
- mixed_samples  in  n_channels*data_width  mixer output frame.
- out_samples  out  n_channels*data_width  registered output frame.
- ready  out  1  high in IDLE once a frame has completed.
- overrun  out  1  sticky: frame arrived while busy.
- timeout  out  1  sticky: watchdog abort occurred.
- flags_clear  in  1  clears overrun and timeout.
- frame_ctr  out  ctr_width  frames ticked into the pipelines (wraps).
- dropped_ctr  out  16  dropped frames (saturates at 0xFFFF).
- state_out  out  3  current state, for debug.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE; gain_samples and out_samples are 0.
- Every output is registered. apply_gain, pipeline_tick and mix default to 0 each cycle.
- IDLE:
  - sample_valid latches in_samples into gain_samples.
  - Drives apply_gain=1 and ready=0 on the same edge; state becomes GAIN.
- GAIN:
  - On gain_done: pipeline_tick=1, frame_ctr+1, state becomes TICK_WAIT.
- TICK_WAIT: unconditional single cycle to PROCESS, so pipelines can drop their ready.
- PROCESS:
  - When &(pipeline_ready | ~pipeline_mask) is true: mix=1, state becomes MIX.
  - An all-zero mask proceeds after one PROCESS cycle.
- MIX:
  - On mix_done: out_samples <= mixed_samples, ready=1, state becomes IDLE.
- Minimum latency with acknowledges arriving the cycle after each request: sample_valid sampled at edge 0 → ready high after edge 6.
- Overrun:
  - sample_valid outside IDLE is ignored; overrun<=1 and dropped_ctr increments (saturating).
  - sample_valid on the edge that leaves MIX is dropped (state not yet IDLE).
- Watchdog:
  - A counter clears on every state change and increments in GAIN, PROCESS and MIX.
  - On reaching timeout_cycles-1: timeout<=1, state becomes IDLE, ready=1, out_samples keeps its previous value, no mix is issued.
- flags_clear clears both sticky flags. If a set event occurs in the same cycle, set wins.
- Stray gain_done or mix_done in other states is ignored.
- pipeline_mask is sampled continuously, so a mid-wait change takes effect immediately.
- Reset asserted mid-frame aborts immediately; no pulse is emitted after deassertion.

Decomposition:
- engine.vh holds the state encodings: SEQ_STATE_IDLE, SEQ_STATE_GAIN, SEQ_STATE_TICK_WAIT, SEQ_STATE_PROCESS, SEQ_STATE_MIX.
- One sub-module, dsp_seq_watchdog: parametrised counter with clear, enable and expired outputs.

Test Plan:
- Nominal frame, n_channels=2, in_samples={16'h1234,16'h8001}, ack one cycle after each request, mixer returns {16'h0AAA,16'h0555}:
  - gain_samples holds {16'h1234,16'h8001};
  - ready rises 6 edges after sample_valid, with out_samples={16'h0AAA,16'h0555} and frame_ctr=1.
- Mask wait, n_pipelines=4, mask=4'b0101:
  - pipeline_ready=4'b1010 held → no mix;
  - ready goes to 4'b0101 → mix pulse on the next edge.
- Overrun: sample_valid asserted for 3 cycles during PROCESS → overrun=1, dropped_ctr=3, frame not restarted.
- Timeout, timeout_cycles=16, mix_done never asserted:
  - timeout=1 and state IDLE 15 cycles after entering MIX;
  - out_samples unchanged, ready=1.
- Clear/set race: flags_clear and an overrun in the same cycle → overrun remains 1; flags_clear alone next cycle → overrun=0.
- Async reset asserted in PROCESS (without a clock edge) → all outputs 0 immediately; after release, no tick or mix until a new sample_valid.

Source files
------------

// File: rtl/dsp_sample_sequencer_pkg.sv
// Shared state encodings and helpers for the DSP sample sequencer.
package dsp_sample_sequencer_pkg;

    typedef enum logic [2:0] {
        SEQ_STATE_IDLE      = 3'd0,
        SEQ_STATE_GAIN      = 3'd1,
        SEQ_STATE_TICK_WAIT = 3'd2,
        SEQ_STATE_PROCESS   = 3'd3,
        SEQ_STATE_MIX       = 3'd4
    } seq_state_e;

    localparam int DROP_W = 16;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dsp_seq_watchdog.sv
// Wait-state watchdog: counts enabled cycles and flags when the next
// increment would reach timeout_cycles-1.
module dsp_seq_watchdog #(
    parameter int timeout_cycles = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles - 2);
    localparam logic [CW-1:0] ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i)  cnt_q <= cnt_q + ONE;
    end

    // Combinational so the abort lands on the same edge the count hits the limit.
    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/dsp_sample_sequencer.sv
// Frame sequencer: gain request, pipeline tick, masked pipeline wait, mix,
// with overrun drop counting and a watchdog abort.
module dsp_sample_sequencer
    import dsp_sample_sequencer_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int n_channels     = 2,
    parameter int n_pipelines    = 2,
    parameter int timeout_cycles = 1024,
    parameter int ctr_width      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [n_channels*data_width-1:0] in_samples,
    input  logic                             sample_valid,
    output logic [n_channels*data_width-1:0] gain_samples,
    output logic                             apply_gain,
    input  logic                             gain_done,
    output logic                             pipeline_tick,
    input  logic [n_pipelines-1:0]           pipeline_ready,
    input  logic [n_pipelines-1:0]           pipeline_mask,
    output logic                             mix,
    input  logic                             mix_done,
    input  logic [n_channels*data_width-1:0] mixed_samples,
    output logic [n_channels*data_width-1:0] out_samples,
    output logic                             ready,
    output logic                             overrun,
    output logic                             timeout,
    input  logic                             flags_clear,
    output logic [ctr_width-1:0]             frame_ctr,
    output logic [DROP_W-1:0]                dropped_ctr,
    output logic [2:0]                       state_out
);
    localparam int FW = n_channels * data_width;
    localparam logic [ctr_width-1:0] CTR_ONE = {{(ctr_width-1){1'b0}}, 1'b1};

    seq_state_e              state_q, state_d;
    logic [FW-1:0]           gain_q, gain_d;
    logic [FW-1:0]           out_q, out_d;
    logic                    apply_gain_q, apply_gain_d;
    logic                    tick_q, tick_d;
    logic                    mix_q, mix_d;
    logic                    ready_q, ready_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;
    logic [ctr_width-1:0]    frame_ctr_q, frame_ctr_d;
    logic [DROP_W-1:0]       dropped_q, dropped_d;
    logic                    wd_clr, wd_en, wd_expired;
    logic                    pipes_done;

    assign pipes_done = &(pipeline_ready | ~pipeline_mask);
    assign wd_en  = (state_q == SEQ_STATE_GAIN) || (state_q == SEQ_STATE_PROCESS) ||
                    (state_q == SEQ_STATE_MIX);
    assign wd_clr = (state_d != state_q);

    dsp_seq_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        gain_d       = gain_q;
        out_d        = out_q;
        apply_gain_d = 1'b0;
        tick_d       = 1'b0;
        mix_d        = 1'b0;
        ready_d      = ready_q;
        overrun_d    = overrun_q;
        timeout_d    = timeout_q;
        frame_ctr_d  = frame_ctr_q;
        dropped_d    = dropped_q;

        // Clear first so a same-cycle set overrides it.
        if (flags_clear) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (sample_valid && state_q != SEQ_STATE_IDLE) begin
            overrun_d = 1'b1;
            dropped_d = sat_inc(dropped_q);
        end

        case (state_q)
            SEQ_STATE_IDLE: begin
                if (sample_valid) begin
                    gain_d       = in_samples;
                    apply_gain_d = 1'b1;
                    ready_d      = 1'b0;
                    state_d      = SEQ_STATE_GAIN;
                end
            end
            SEQ_STATE_GAIN: begin
                if (gain_done) begin
                    tick_d      = 1'b1;
                    frame_ctr_d = frame_ctr_q + CTR_ONE;
                    state_d     = SEQ_STATE_TICK_WAIT;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = SEQ_STATE_IDLE;
                end
            end
            SEQ_STATE_TICK_WAIT: state_d = SEQ_STATE_PROCESS;
            SEQ_STATE_PROCESS: begin
                if (pipes_done) begin
                    mix_d   = 1'b1;
                    state_d = SEQ_STATE_MIX;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = SEQ_STATE_IDLE;
                end
            end
            SEQ_STATE_MIX: begin
                if (mix_done) begin
                    out_d   = mixed_samples;
                    ready_d = 1'b1;
                    state_d = SEQ_STATE_IDLE;
                end else if (wd_expired) begin
                    timeout_d = 1'b1;
                    ready_d   = 1'b1;
                    state_d   = SEQ_STATE_IDLE;
                end
            end
            default: state_d = SEQ_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEQ_STATE_IDLE;
            gain_q       <= '0;
            out_q        <= '0;
            apply_gain_q <= 1'b0;
            tick_q       <= 1'b0;
            mix_q        <= 1'b0;
            ready_q      <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
            frame_ctr_q  <= '0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            out_q        <= out_d;
            apply_gain_q <= apply_gain_d;
            tick_q       <= tick_d;
            mix_q        <= mix_d;
            ready_q      <= ready_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
            frame_ctr_q  <= frame_ctr_d;
            dropped_q    <= dropped_d;
        end
    end

    assign gain_samples  = gain_q;
    assign out_samples   = out_q;
    assign apply_gain    = apply_gain_q;
    assign pipeline_tick = tick_q;
    assign mix           = mix_q;
    assign ready         = ready_q;
    assign overrun       = overrun_q;
    assign timeout       = timeout_q;
    assign frame_ctr     = frame_ctr_q;
    assign dropped_ctr   = dropped_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_dsp_sample_sequencer.sv
// Directed bench for dsp_sample_sequencer with an output-frame scoreboard.
module tb_dsp_sample_sequencer;
    localparam int DW = 16;
    localparam int NC = 2;
    localparam int NP = 4;
    localparam int TO = 16;
    localparam int CTRW = 32;

    localparam logic [2:0] S_IDLE = 3'd0, S_GAIN = 3'd1, S_TW = 3'd2,
                           S_PROC = 3'd3, S_MIX = 3'd4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NC*DW-1:0]   in_samples, gain_samples, mixed_samples, out_samples;
    logic               sample_valid, apply_gain, gain_done, pipeline_tick;
    logic [NP-1:0]      pipeline_ready, pipeline_mask;
    logic               mix, mix_done, ready, overrun, timeout, flags_clear;
    logic [CTRW-1:0]    frame_ctr;
    logic [15:0]        dropped_ctr;
    logic [2:0]         state_out;

    int tests = 0;
    int failed = 0;
    logic [NC*DW-1:0] exp_q[$];
    logic [NC*DW-1:0] last_out;

    always #5 clk = ~clk;

    dsp_sample_sequencer #(
        .data_width(DW), .n_channels(NC), .n_pipelines(NP),
        .timeout_cycles(TO), .ctr_width(CTRW)
    ) dut (
        .clk(clk), .reset(reset), .in_samples(in_samples), .sample_valid(sample_valid),
        .gain_samples(gain_samples), .apply_gain(apply_gain), .gain_done(gain_done),
        .pipeline_tick(pipeline_tick), .pipeline_ready(pipeline_ready),
        .pipeline_mask(pipeline_mask), .mix(mix), .mix_done(mix_done),
        .mixed_samples(mixed_samples), .out_samples(out_samples), .ready(ready),
        .overrun(overrun), .timeout(timeout), .flags_clear(flags_clear),
        .frame_ctr(frame_ctr), .dropped_ctr(dropped_ctr), .state_out(state_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag);
        logic [NC*DW-1:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'(out_samples), 64'(e));
        end
    endtask

    // Drive a frame and ack the gain; returns 1ns after the edge that enters PROCESS.
    task automatic start_frame(input logic [NC*DW-1:0] d);
        sample_valid = 1'b1;
        in_samples   = d;
        adv();
        sample_valid = 1'b0;
        adv();
        gain_done = 1'b1;
        adv();
        gain_done = 1'b0;
        adv();
    endtask

    initial begin
        reset = 1'b1;
        in_samples = '0; sample_valid = 1'b0; gain_done = 1'b0;
        pipeline_ready = '0; pipeline_mask = '1; mix_done = 1'b0;
        mixed_samples = '0; flags_clear = 1'b0;
        #1;
        chk("rst_state", 64'(state_out), 64'(S_IDLE));
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_gain_samples", 64'(gain_samples), 64'd0);
        chk("rst_out_samples", 64'(out_samples), 64'd0);
        chk("rst_frame_ctr", 64'(frame_ctr), 64'd0);
        adv(); adv();
        reset = 1'b0;
        adv();

        // Nominal frame, acks one cycle after each request.
        mixed_samples = 32'h0AAA_0555;
        exp_q.push_back(32'h0AAA_0555);
        sample_valid = 1'b1;
        in_samples   = 32'h1234_8001;
        adv();                                   // edge 0
        sample_valid = 1'b0;
        chk("nom_apply_gain", 64'(apply_gain), 64'd1);
        chk("nom_state_gain", 64'(state_out), 64'(S_GAIN));
        chk("nom_gain_samples", 64'(gain_samples), 64'h1234_8001);
        adv();                                   // edge 1
        chk("nom_apply_gain_pulse", 64'(apply_gain), 64'd0);
        gain_done = 1'b1;
        adv();                                   // edge 2
        gain_done = 1'b0;
        chk("nom_tick", 64'(pipeline_tick), 64'd1);
        chk("nom_frame_ctr", 64'(frame_ctr), 64'd1);
        chk("nom_state_tw", 64'(state_out), 64'(S_TW));
        adv();                                   // edge 3
        chk("nom_state_proc", 64'(state_out), 64'(S_PROC));
        chk("nom_tick_pulse", 64'(pipeline_tick), 64'd0);
        pipeline_ready = 4'hF;
        adv();                                   // edge 4
        pipeline_ready = 4'h0;
        chk("nom_mix", 64'(mix), 64'd1);
        chk("nom_state_mix", 64'(state_out), 64'(S_MIX));
        adv();                                   // edge 5
        chk("nom_ready_early", 64'(ready), 64'd0);
        mix_done = 1'b1;
        adv();                                   // edge 6
        mix_done = 1'b0;
        chk("nom_ready", 64'(ready), 64'd1);
        chk("nom_state_idle", 64'(state_out), 64'(S_IDLE));
        sb_check("nom_out_samples");

        // Mask wait: only pipelines 0 and 2 matter.
        pipeline_mask = 4'b0101;
        mixed_samples = 32'hBEEF_0001;
        exp_q.push_back(32'hBEEF_0001);
        start_frame(32'h0000_1111);
        pipeline_ready = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("mask_hold_nomix", 64'(mix), 64'd0);
            chk("mask_hold_state", 64'(state_out), 64'(S_PROC));
        end
        pipeline_ready = 4'b0101;
        adv();
        pipeline_ready = 4'b0000;
        chk("mask_mix", 64'(mix), 64'd1);
        adv();
        mix_done = 1'b1;
        adv();
        mix_done = 1'b0;
        chk("mask_ready", 64'(ready), 64'd1);
        sb_check("mask_out_samples");
        chk("mask_frame_ctr", 64'(frame_ctr), 64'd2);

        // Overrun: three stray frames while in PROCESS.
        pipeline_mask = 4'hF;
        mixed_samples = 32'h5555_AAAA;
        exp_q.push_back(32'h5555_AAAA);
        start_frame(32'h2222_3333);
        sample_valid = 1'b1;
        in_samples   = 32'hDEAD_DEAD;
        adv(); adv(); adv();
        sample_valid = 1'b0;
        chk("ovr_flag", 64'(overrun), 64'd1);
        chk("ovr_dropped", 64'(dropped_ctr), 64'd3);
        chk("ovr_state", 64'(state_out), 64'(S_PROC));
        chk("ovr_gain_samples", 64'(gain_samples), 64'h2222_3333);
        chk("ovr_frame_ctr", 64'(frame_ctr), 64'd3);
        pipeline_ready = 4'hF;
        adv();
        pipeline_ready = 4'h0;
        adv();
        mix_done = 1'b1;
        adv();
        mix_done = 1'b0;
        chk("ovr_ready", 64'(ready), 64'd1);
        sb_check("ovr_out_samples");
        last_out = 32'h5555_AAAA;

        // Clear/set race, then watchdog timeout in MIX.
        exp_q.push_back(last_out);
        start_frame(32'h4444_5555);
        flags_clear  = 1'b1;
        sample_valid = 1'b1;
        adv();
        flags_clear  = 1'b0;
        sample_valid = 1'b0;
        chk("race_set_wins", 64'(overrun), 64'd1);
        chk("race_dropped", 64'(dropped_ctr), 64'd4);
        flags_clear = 1'b1;
        adv();
        flags_clear = 1'b0;
        chk("race_cleared", 64'(overrun), 64'd0);
        pipeline_ready = 4'hF;
        adv();                                   // enters MIX
        pipeline_ready = 4'h0;
        chk("to_mix", 64'(mix), 64'd1);
        for (int k = 1; k <= 14; k++) adv();
        chk("to_not_yet", 64'(timeout), 64'd0);
        chk("to_still_mix", 64'(state_out), 64'(S_MIX));
        adv();                                   // 15 cycles after entering MIX
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_state_idle", 64'(state_out), 64'(S_IDLE));
        chk("to_ready", 64'(ready), 64'd1);
        chk("to_no_mix", 64'(mix), 64'd0);
        sb_check("to_out_kept");
        chk("to_frame_ctr", 64'(frame_ctr), 64'd4);
        flags_clear = 1'b1;
        adv();
        flags_clear = 1'b0;
        chk("to_cleared", 64'(timeout), 64'd0);

        // Asynchronous reset mid-frame.
        start_frame(32'h7777_8888);
        chk("arst_pre_state", 64'(state_out), 64'(S_PROC));
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", 64'(state_out), 64'(S_IDLE));
        chk("arst_gain_samples", 64'(gain_samples), 64'd0);
        chk("arst_frame_ctr", 64'(frame_ctr), 64'd0);
        chk("arst_flags", 64'({overrun, timeout, ready}), 64'd0);
        chk("arst_out_samples", 64'(out_samples), 64'd0);
        chk("arst_dropped", 64'(dropped_ctr), 64'd0);
        pipeline_ready = 4'hF;
        gain_done = 1'b1;
        mix_done  = 1'b1;
        adv();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("arst_no_pulse", 64'({apply_gain, pipeline_tick, mix}), 64'd0);
            chk("arst_idle", 64'(state_out), 64'(S_IDLE));
        end
        gain_done = 1'b0;
        mix_done  = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
